seq_bit_serializer: RTL

- Parallel-to-serial bit-stream source that drives the serial input `x` of the sequence-detector FSMs (e.g. the 001/100 Mealy overlap detector).
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock.
- Supports back-to-back words with no idle gap, so long test or functional streams can be chained.

---
 rtl/seq_pkg.sv | 11 +
 rtl/seq_bit_serializer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the sequence-detector stimulus
// blocks.
//   ser_state_t : serializer FSM state encoding.
//   SEQ_WORD_W  : default serializer word width.
package seq_pkg;

    typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

    localparam int unsigned SEQ_WORD_W = 20;

endpackage

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial bit source that feeds the serial
// input of the sequence-detector FSMs. A WIDTH-bit word is accepted over a
// valid/ready handshake and emitted one bit per clock. Words can be chained
// back-to-back with no idle gap.
//
// Parameters:
//   WIDTH     : bits per word (>= 2).
//   MSB_FIRST : 1 = emit bit WIDTH-1 first, 0 = emit bit 0 first.
//   IDLE_BIT  : level on x while no word is being shifted.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   load_data   in   word to serialize (captured only at acceptance)
//   load_valid  in   load_data is valid
//   load_ready  out  word can be accepted this cycle (combinational)
//   x           out  serial bit (registered)
//   x_valid     out  x carries a word bit this cycle
//   busy        out  a word is being shifted
//   done        out  pulse while x carries the last bit of a word
//   repeat_word in   only with SEQ_SERIALIZER_REPEAT_EN defined: re-emit the
//                    captured word when no new word is accepted at its end
//
// Build option: define SEQ_SERIALIZER_REPEAT_EN to add repeat_word.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH     = SEQ_WORD_W,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
`ifdef SEQ_SERIALIZER_REPEAT_EN
    ,
    input  logic             repeat_word
`endif
);

    localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PEN_IDX  = CW'(WIDTH - 2);

    // The shift register rotates rather than shifts: the bit to emit next is
    // always at the head position, and after WIDTH emissions the register
    // holds the original word again, which is what makes repeat free.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) return w[WIDTH-1];
        else           return w[0];
    endfunction

    function automatic logic [WIDTH-1:0] rot_word(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) return {w[WIDTH-2:0], w[WIDTH-1]};
        else           return {w[0], w[WIDTH-1:1]};
    endfunction

    ser_state_t       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             last_bit;
    logic             accept;
    logic             rep_go;

`ifdef SEQ_SERIALIZER_REPEAT_EN
    assign rep_go = repeat_word;
`else
    assign rep_go = 1'b0;
`endif

    assign last_bit   = (state_q == SER_SHIFT) && (count_q == LAST_IDX);
    assign load_ready = (state_q == SER_IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shreg_d   = shreg_q;
        x_d       = IDLE_BIT;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            SER_IDLE: begin
                if (accept) begin
                    state_d   = SER_SHIFT;
                    count_d   = '0;
                    shreg_d   = rot_word(load_data);
                    x_d       = head_bit(load_data);
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            SER_SHIFT: begin
                if (!last_bit) begin
                    count_d   = count_q + CW'(1);
                    shreg_d   = rot_word(shreg_q);
                    x_d       = head_bit(shreg_q);
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = (count_q == PEN_IDX);
                end else if (accept) begin
                    count_d   = '0;
                    shreg_d   = rot_word(load_data);
                    x_d       = head_bit(load_data);
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end else if (rep_go) begin
                    // shreg_q is back to the captured word here.
                    count_d   = '0;
                    shreg_d   = rot_word(shreg_q);
                    x_d       = head_bit(shreg_q);
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    state_d = SER_IDLE;
                    count_d = '0;
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SER_IDLE;
            count_q   <= '0;
            shreg_q   <= '0;
            x_q       <= IDLE_BIT;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shreg_q   <= shreg_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
